bin_to_bcd_converter: RTL



---
 rtl/bin_to_bcd_converter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter
// Sequential double-dabble converter: a 14-bit binary value becomes four BCD
// digits using one shift-and-adjust step per clock. The start/busy/done
// handshake gives 14 cycles of latency. Inputs above 9999 saturate to 9999
// and raise overflow.
//
// Ports
//   bcd_clk_signal  in   clock, rising edge
//   bcd_reset_n     in   asynchronous active-low reset
//   bin_value[13:0] in   value to convert, sampled when a convert is accepted
//   convert         in   start request, accepted only while busy=0
//   busy            out  conversion in progress
//   done            out  one-cycle pulse when the digit outputs update
//   bcd_thousands/bcd_hundreds/bcd_tens/bcd_ones [3:0] out  registered digits
//   overflow        out  captured value was >9999, so the digits show 9999
//   digit_blank[3:0] out leading-zero blank flags, [3]=thousands .. [0]=ones
//
// Configuration macro: BCD_LEADING_ZERO_BLANK_EN enables the registered
// leading-zero blank flags. When the macro is not defined, digit_blank is
// tied to zero.
module bin_to_bcd_converter (
  input  logic        bcd_clk_signal,
  input  logic        bcd_reset_n,
  input  logic [13:0] bin_value,
  input  logic        convert,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd_thousands,
  output logic [3:0]  bcd_hundreds,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic        overflow,
  output logic [3:0]  digit_blank
);

  localparam int unsigned BIN_W     = 14;
  localparam int unsigned DIG_W     = 4;
  localparam int unsigned NUM_DIG   = 4;
  localparam int unsigned BCD_W     = DIG_W * NUM_DIG;
  localparam int unsigned SR_W      = BCD_W + BIN_W;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_STEP = BIN_W - 1;
  localparam int unsigned MAX_DEC   = 9999;

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;

  state_t             r_state, w_nxt_state;
  logic [SR_W-1:0]    r_shift, w_nxt_shift;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic               r_ovf_pend, w_nxt_ovf_pend;
  logic               r_busy, w_nxt_busy;
  logic               r_done, w_nxt_done;
  logic               r_ovf, w_nxt_ovf;
  logic [DIG_W-1:0]   r_th, r_hu, r_te, r_on;
  logic [DIG_W-1:0]   w_nxt_th, w_nxt_hu, w_nxt_te, w_nxt_on;
  logic [SR_W-1:0]    w_adj;
  logic [SR_W-1:0]    w_step;

  // Add-3 adjust on each BCD nibble >=5, then the one-bit left shift.
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      if (r_shift[BIN_W + DIG_W*i +: DIG_W] >= 4'd5)
        w_adj[BIN_W + DIG_W*i +: DIG_W] = 4'(r_shift[BIN_W + DIG_W*i +: DIG_W] + 4'd3);
    end
    w_step = {w_adj[SR_W-2:0], 1'b0};
  end

  // Next-state and output logic.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_shift    = r_shift;
    w_nxt_cnt      = r_cnt;
    w_nxt_ovf_pend = r_ovf_pend;
    w_nxt_busy     = r_busy;
    w_nxt_done     = 1'b0;
    w_nxt_ovf      = r_ovf;
    w_nxt_th       = r_th;
    w_nxt_hu       = r_hu;
    w_nxt_te       = r_te;
    w_nxt_on       = r_on;
    case (r_state)
      S_IDLE: begin
        if (convert) begin
          w_nxt_shift    = {BCD_W'(0), bin_value};
          w_nxt_ovf_pend = (bin_value > BIN_W'(MAX_DEC));
          w_nxt_cnt      = '0;
          w_nxt_busy     = 1'b1;
          w_nxt_state    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_nxt_shift = w_step;
        w_nxt_cnt   = CNT_W'(r_cnt + CNT_W'(1));
        if (r_cnt == CNT_W'(LAST_STEP)) begin
          w_nxt_th    = r_ovf_pend ? 4'd9 : w_step[SR_W-1 -: DIG_W];
          w_nxt_hu    = r_ovf_pend ? 4'd9 : w_step[SR_W-1-DIG_W -: DIG_W];
          w_nxt_te    = r_ovf_pend ? 4'd9 : w_step[SR_W-1-2*DIG_W -: DIG_W];
          w_nxt_on    = r_ovf_pend ? 4'd9 : w_step[SR_W-1-3*DIG_W -: DIG_W];
          w_nxt_ovf   = r_ovf_pend;
          w_nxt_done  = 1'b1;
          w_nxt_busy  = 1'b0;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge bcd_clk_signal or negedge bcd_reset_n) begin
    if (!bcd_reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_th       <= '0;
      r_hu       <= '0;
      r_te       <= '0;
      r_on       <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_shift    <= w_nxt_shift;
      r_cnt      <= w_nxt_cnt;
      r_ovf_pend <= w_nxt_ovf_pend;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_ovf      <= w_nxt_ovf;
      r_th       <= w_nxt_th;
      r_hu       <= w_nxt_hu;
      r_te       <= w_nxt_te;
      r_on       <= w_nxt_on;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [3:0] r_blank, w_nxt_blank;

  // A digit blanks when it and every higher digit are zero; ones never blanks.
  always_comb begin
    w_nxt_blank = r_blank;
    if (w_nxt_done) begin
      w_nxt_blank[3] = (w_nxt_th == 4'd0);
      w_nxt_blank[2] = (w_nxt_th == 4'd0) && (w_nxt_hu == 4'd0);
      w_nxt_blank[1] = (w_nxt_th == 4'd0) && (w_nxt_hu == 4'd0) && (w_nxt_te == 4'd0);
      w_nxt_blank[0] = 1'b0;
    end
  end

  always_ff @(posedge bcd_clk_signal or negedge bcd_reset_n) begin
    if (!bcd_reset_n) r_blank <= 4'b1110;
    else              r_blank <= w_nxt_blank;
  end

  assign digit_blank = r_blank;
`else
  assign digit_blank = 4'b0000;
`endif

  assign busy          = r_busy;
  assign done          = r_done;
  assign overflow      = r_ovf;
  assign bcd_thousands = r_th;
  assign bcd_hundreds  = r_hu;
  assign bcd_tens      = r_te;
  assign bcd_ones      = r_on;

endmodule
